// File: rtl/layer_xfer_ctrl_pkg.sv
// Shared types for the layer transfer controller: FSM states, index width
// and the (col,row,ch) index triple used by the counter and the delay line.
package layer_xfer_ctrl_pkg;

  localparam int IDX_W = 16;

  typedef logic [IDX_W-1:0] idx_t;

  // Packed so a whole triple can be registered or compared in one step.
  typedef struct packed {
    idx_t ch;
    idx_t row;
    idx_t col;
  } idx3_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COMPUTE,
    ST_WAIT,
    ST_XFER,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/layer_xfer_ctrl_idx_counter3.sv
// Nested col/row/channel counter. Column runs fastest; each field wraps at
// its maximum and the whole triple returns to (0,0,0) after the last index.
module idx_counter3
  import layer_xfer_ctrl_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int DIM    = 26
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  en,
  input  logic  clr,
  output idx3_t idx,
  output logic  last
);

  localparam idx_t COL_MAX = idx_t'(DIM - 1);
  localparam idx_t ROW_MAX = idx_t'(DIM - 1);
  localparam idx_t CH_MAX  = idx_t'(NUM_CH - 1);

  idx3_t idx_q, idx_d;
  logic  col_last, row_last, ch_last;

  assign col_last = (idx_q.col == COL_MAX);
  assign row_last = (idx_q.row == ROW_MAX);
  assign ch_last  = (idx_q.ch  == CH_MAX);
  assign last     = col_last && row_last && ch_last;
  assign idx      = idx_q;

  // Next index: clear wins, otherwise step col and carry into row and channel.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (en) begin
      if (!col_last) begin
        idx_d.col = idx_q.col + 16'd1;
      end else begin
        idx_d.col = '0;
        if (!row_last) begin
          idx_d.row = idx_q.row + 16'd1;
        end else begin
          idx_d.row = '0;
          idx_d.ch  = ch_last ? '0 : idx_q.ch + 16'd1;
        end
      end
    end
  end

  // Index register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
    if (!reset) idx_q <= '0;
    else        idx_q <= idx_d;
  end

endmodule

// File: rtl/layer_xfer_ctrl.sv
// Layer transfer controller: kicks the producer layer, waits for its output to
// be valid, then streams every output element into the consumer's input
// memory, compensating for the producer memory read latency with a delay line.
module layer_xfer_ctrl
  import layer_xfer_ctrl_pkg::*;
#(
  parameter int NUM_CH   = 16,
  parameter int DIM      = 26,
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        layer_start,
  input  logic        layer_done,
  output logic [15:0] rd_index0,
  output logic [15:0] rd_index1,
  output logic [15:0] rd_index2,
  output logic [15:0] wr_index0,
  output logic [15:0] wr_index1,
  output logic [15:0] wr_index2,
  output logic        wr_en
);

  localparam logic [2:0] DRAIN_LAST = 3'(READ_LAT - 1);

  state_t     state_q, state_d;
  logic [2:0] drain_q, drain_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ls_q, ls_d;

  idx3_t rd_idx;
  logic  rd_last;
  logic  cnt_en;

  // Read-side counter only runs while transferring; it is parked at zero
  // otherwise, which also keeps rd_index at 0 outside XFER.
  assign cnt_en = (state_q == ST_XFER);

  idx_counter3 #(
    .NUM_CH(NUM_CH),
    .DIM   (DIM)
  ) u_idx_counter3 (
    .clk  (clk),
    .reset(reset),
    .en   (cnt_en),
    .clr  (!cnt_en),
    .idx  (rd_idx),
    .last (rd_last)
  );

  // Next-state and next-output decode; outputs are derived from the next state
  // so they come straight out of flops.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_COMPUTE;
      ST_COMPUTE: state_d = ST_WAIT;
      ST_WAIT:    if (layer_done) state_d = ST_XFER;
      ST_XFER: begin
        if (rd_last) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = ST_IDLE;
        else                       drain_d = drain_q + 3'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    ls_d   = (state_d == ST_COMPUTE);
    done_d = (state_d == ST_DRAIN) && (drain_d == DRAIN_LAST);
  end

  // FSM state and registered control outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ls_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ls_q    <= ls_d;
    end
  end

  // Read-latency delay line: valid bits shift every cycle, indices only move
  // with a valid entry so the output index holds its last written value.
  logic  line_v_q   [READ_LAT];
  logic  line_v_d   [READ_LAT];
  idx3_t line_idx_q [READ_LAT];
  idx3_t line_idx_d [READ_LAT];

  // Delay line next values.
  always_comb begin
    line_v_d   = line_v_q;
    line_idx_d = line_idx_q;
    line_v_d[0] = cnt_en;
    if (cnt_en) line_idx_d[0] = rd_idx;
    for (int k = 1; k < READ_LAT; k++) begin
      line_v_d[k] = line_v_q[k-1];
      if (line_v_q[k-1]) line_idx_d[k] = line_idx_q[k-1];
    end
  end

  // Delay line registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: this small array is reset on purpose; an aborted run must leave no valid write behind.
      for (int k = 0; k < READ_LAT; k++) begin
        line_v_q[k]   <= 1'b0;
        line_idx_q[k] <= '0;
      end
    end else begin
      line_v_q   <= line_v_d;
      line_idx_q <= line_idx_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign layer_start = ls_q;
  assign rd_index0   = rd_idx.col;
  assign rd_index1   = rd_idx.row;
  assign rd_index2   = rd_idx.ch;
  assign wr_en       = line_v_q[READ_LAT-1];
  assign wr_index0   = line_idx_q[READ_LAT-1].col;
  assign wr_index1   = line_idx_q[READ_LAT-1].row;
  assign wr_index2   = line_idx_q[READ_LAT-1].ch;

endmodule

// File: tb/tb_layer_xfer_ctrl.sv
// Bench for layer_xfer_ctrl: three instances (small/lat1, small/lat3, full size)
// driven with randomised handshake timing and compared every cycle against an
// arithmetic timeline of when each read, write and pulse must happen.
module tb_layer_xfer_ctrl;

  localparam int NCH [3] = '{2, 2, 16};
  localparam int DIMS[3] = '{3, 3, 26};
  localparam int LATS[3] = '{1, 3, 1};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start_v[3], ld_v[3];
  logic        busy_w[3], done_w[3], ls_w[3], wr_en_w[3];
  logic [15:0] rd0_w[3], rd1_w[3], rd2_w[3], wr0_w[3], wr1_w[3], wr2_w[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    layer_xfer_ctrl #(
      .NUM_CH  (NCH[g]),
      .DIM     (DIMS[g]),
      .READ_LAT(LATS[g])
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start_v[g]),
      .busy       (busy_w[g]),
      .done       (done_w[g]),
      .layer_start(ls_w[g]),
      .layer_done (ld_v[g]),
      .rd_index0  (rd0_w[g]),
      .rd_index1  (rd1_w[g]),
      .rd_index2  (rd2_w[g]),
      .wr_index0  (wr0_w[g]),
      .wr_index1  (wr1_w[g]),
      .wr_index2  (wr2_w[g]),
      .wr_en      (wr_en_w[g])
    );
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [47:0] hold_v[3];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Element i of the transfer order, column fastest: {ch,row,col}.
  function automatic logic [47:0] exp_idx(input int i, input int dim);
    int col, row, ch;
    col = i % dim;
    row = (i / dim) % dim;
    ch  = i / (dim * dim);
    return {16'(ch), 16'(row), 16'(col)};
  endfunction

  task automatic check_all_zero(input string tag, input int d);
    check({tag, "_busy"},  busy_w[d],  1'b0);
    check({tag, "_done"},  done_w[d],  1'b0);
    check({tag, "_ls"},    ls_w[d],    1'b0);
    check({tag, "_wr_en"}, wr_en_w[d], 1'b0);
    check({tag, "_rd"}, {rd2_w[d], rd1_w[d], rd0_w[d]}, 48'd0);
    check({tag, "_wr"}, {wr2_w[d], wr1_w[d], wr0_w[d]}, 48'd0);
  endtask

  // One run on instance d. Start is driven in cycle 0; layer_done rises
  // ld_delay cycles after the layer_start cycle (or is high throughout).
  // extra_start > 0 pulses start again in that cycle; abort_at > 0 pulls
  // reset during that write number.
  task automatic run(input int d, input int ld_delay, input bit ld_perm,
                     input int extra_start, input bit start_at_done, input int abort_at);
    int n, lat, ls_c, acc, rd_first, wr_first, done_c;
    int writes, dones, ls_cnt;
    bit aborted;
    bit e_rd, e_wr, e_busy;
    logic [47:0] e_rdi;
    n        = NCH[d] * DIMS[d] * DIMS[d];
    lat      = LATS[d];
    ls_c     = 1;
    acc      = ls_c + ((ld_perm || ld_delay < 1) ? 1 : ld_delay);
    rd_first = acc + 1;
    wr_first = rd_first + lat;
    done_c   = acc + n + lat;
    writes = 0; dones = 0; ls_cnt = 0; aborted = 1'b0;
    if (ld_perm) ld_v[d] = 1'b1;
    for (int c = 0; c <= done_c + 3 && !aborted; c++) begin
      @(negedge clk);
      e_rd   = (c >= rd_first) && (c < rd_first + n);
      e_wr   = (c >= wr_first) && (c < wr_first + n);
      e_busy = (c >= 1) && (c <= done_c);
      e_rdi  = e_rd ? exp_idx(c - rd_first, DIMS[d]) : 48'd0;
      if (e_wr) hold_v[d] = exp_idx(c - wr_first, DIMS[d]);
      check("busy",        busy_w[d],  e_busy);
      check("done",        done_w[d],  c == done_c);
      check("layer_start", ls_w[d],    c == ls_c);
      check("wr_en",       wr_en_w[d], e_wr);
      check("rd_index", {rd2_w[d], rd1_w[d], rd0_w[d]}, e_rdi);
      check("wr_index", {wr2_w[d], wr1_w[d], wr0_w[d]}, hold_v[d]);
      writes += int'(wr_en_w[d]);
      dones  += int'(done_w[d]);
      ls_cnt += int'(ls_w[d]);
      if (abort_at > 0 && e_wr && (c - wr_first + 1) == abort_at) begin
        #1 reset = 1'b0;
        #1;
        check_all_zero("abort", d);
        for (int k = 0; k < 3; k++) hold_v[k] = 48'd0;
        start_v[d] = 1'b0;
        ld_v[d]    = 1'b0;
        aborted    = 1'b1;
        @(negedge clk) reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("post_abort_wr_en", wr_en_w[d], 1'b0);
          check("post_abort_busy",  busy_w[d],  1'b0);
        end
      end else begin
        start_v[d] = (c == 0) || (c == extra_start) || (start_at_done && c == done_c);
        ld_v[d]    = ld_perm || (c >= ls_c + ld_delay);
      end
    end
    if (!aborted) begin
      check("write_count", writes, n);
      check("done_count",  dones,  1);
      check("ls_count",    ls_cnt, 1);
    end
    start_v[d] = 1'b0;
    ld_v[d]    = 1'b0;
  endtask

  initial begin
    int d, dly, xs;
    bit sad;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0;
      ld_v[k]    = 1'b0;
      hold_v[k]  = 48'd0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) check_all_zero("reset", k);
    reset = 1'b1;

    run(0, 5, 1'b0, -1, 1'b0, 0);   // basic, latency 1
    run(1, 5, 1'b0, -1, 1'b0, 0);   // latency 3
    run(0, 2, 1'b0, 10, 1'b1, 0);   // start during XFER and with done
    run(0, 0, 1'b1, -1, 1'b0, 0);   // layer_done stuck high
    run(0, 3, 1'b0, -1, 1'b0, 7);   // reset at write 7
    run(0, 1, 1'b0, -1, 1'b0, 0);   // fresh run after abort

    for (int r = 0; r < 6; r++) begin
      d   = int'($urandom_range(0, 1));
      dly = int'($urandom_range(0, 8));
      xs  = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, 20));
      sad = 1'($urandom_range(0, 1));
      run(d, dly, 1'b0, xs, sad, 0);
    end

    run(2, int'($urandom_range(1, 4)), 1'b0, -1, 1'b1, 0);  // full-size run

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
